// File: rtl/dct_pkg.sv
// Shared constants, formats and helpers for the 8-point 1D DCT/IDCT stages.
// Samples are 16-bit sign-magnitude (4 fraction bits); cosines are 15-bit Q0.15 magnitudes.
package dct_pkg;

   localparam int SAMPLE_W  = 16;
   localparam int COEF_W    = 15;
   localparam int ACC_W     = 34;
   localparam int PROD_W    = SAMPLE_W + COEF_W;
   localparam int NUM_LANES = 4;
   localparam int VEC_N     = 8;

   localparam logic [COEF_W-1:0] C1 = 15'h3EC5;
   localparam logic [COEF_W-1:0] C2 = 15'h3B20;
   localparam logic [COEF_W-1:0] C3 = 15'h3536;
   localparam logic [COEF_W-1:0] C4 = 15'h2D41;
   localparam logic [COEF_W-1:0] C5 = 15'h238E;
   localparam logic [COEF_W-1:0] C6 = 15'h187D;
   localparam logic [COEF_W-1:0] C7 = 15'h0C7C;

   typedef enum logic [1:0] {IDLE = 2'd0, MAC = 2'd1, BFLY = 2'd2, OUT = 2'd3} state_t;

   typedef struct packed {
      logic              neg;
      logic              zero;
      logic [COEF_W-1:0] mag;
   } coef_t;

   function automatic logic [COEF_W-1:0] cval(input logic [4:0] m);
      case (m)
         5'd1:    cval = C1;
         5'd2:    cval = C2;
         5'd3:    cval = C3;
         5'd4:    cval = C4;
         5'd5:    cval = C5;
         5'd6:    cval = C6;
         5'd7:    cval = C7;
         default: cval = '0;
      endcase
   endfunction

   // 0.5*cos((2n+1)k*pi/16) folded onto +/-C1..C7; the 5-bit product is already mod 32.
   function automatic coef_t coef_sel(input logic [1:0] n, input logic [2:0] k);
      coef_t      c;
      logic [4:0] m;
      m = {2'b00, n, 1'b1} * {2'b00, k};
      if (m > 5'd16) m = 5'd0 - m;
      c = '0;
      if (k == 3'd0)      c.mag = C4;
      else if (m < 5'd8)  c.mag = cval(m);
      else if (m == 5'd8) c.zero = 1'b1;
      else begin
         c.neg = 1'b1;
         c.mag = cval(5'd16 - m);
      end
      return c;
   endfunction

   function automatic logic signed [SAMPLE_W-1:0] sm_to_tc(input logic [SAMPLE_W-1:0] s);
      logic signed [SAMPLE_W-1:0] mag;
      mag = {1'b0, s[SAMPLE_W-2:0]};
      return s[SAMPLE_W-1] ? -mag : mag;
   endfunction

   // Drops 15 of the 19 fraction bits, rounding half away from zero; never yields -0.
   function automatic logic [SAMPLE_W-1:0] tc_to_sm_sat(input logic signed [ACC_W-1:0] v);
      logic [ACC_W-1:0] mag, q;
      logic             neg;
      neg = v[ACC_W-1];
      mag = neg ? -v : v;
      q   = (mag + ACC_W'(16384)) >> 15;
      if (q > ACC_W'(32767)) return {neg, 15'h7FFF};
      return {neg && (q != '0), q[SAMPLE_W-2:0]};
   endfunction

endpackage

// File: rtl/idct_mac_lane.sv
// One IDCT output lane n: multiplies the current coefficient by its cosine term and
// accumulates even-k terms into e and odd-k terms into o for the final butterfly.
module idct_mac_lane import dct_pkg::*; #(
   parameter int LANE = 0
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       en,
   input  logic                       odd,
   input  logic [2:0]                 k,
   input  logic signed [SAMPLE_W-1:0] y,
   output logic signed [ACC_W-1:0]    e,
   output logic signed [ACC_W-1:0]    o
);

   coef_t                    cs;
   logic signed [PROD_W-1:0] ya, ca, prod;
   logic signed [ACC_W-1:0]  term;

   assign cs   = coef_sel(2'(LANE), k);
   assign ya   = PROD_W'(y);
   assign ca   = PROD_W'({1'b0, cs.mag});
   assign prod = ya * ca;

   always_comb begin
      term = ACC_W'(prod);
      if (cs.zero)     term = '0;
      else if (cs.neg) term = -ACC_W'(prod);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         e <= '0;
         o <= '0;
      end else if (clr) begin
         e <= '0;
         o <= '0;
      end else if (en) begin
         if (odd) o <= o + term;
         else     e <= e + term;
      end
   end

endmodule

// File: rtl/idct_1d.sv
// Sequential 8-point 1D inverse DCT: 8 MAC cycles over four lanes, one butterfly
// cycle, then the result is held until the consumer takes it.
module idct_1d import dct_pkg::*; (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] y_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] x_out
);

   state_t                              state;
   logic [2:0]                          k;
   logic [VEC_N-1:0][SAMPLE_W-1:0]      vreg, vin, xs;
   logic [NUM_LANES-1:0][ACC_W-1:0]     e, o;
   logic                                accept, en;

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == OUT);
   assign accept    = in_ready && in_valid;
   assign en        = (state == MAC);

   // Coefficients are stored already in two's complement so the lanes share one conversion.
   always_comb begin
      vin = '0;
      for (int i = 0; i < VEC_N; i++) vin[i] = sm_to_tc(y_in[i*SAMPLE_W +: SAMPLE_W]);
   end

   for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
      idct_mac_lane #(.LANE(n)) u_lane (
         .clk (clk),
         .rst (rst),
         .clr (accept),
         .en  (en),
         .odd (k[0]),
         .k   (k),
         .y   ($signed(vreg[k])),
         .e   (e[n]),
         .o   (o[n])
      );
      assign xs[n]         = tc_to_sm_sat($signed(e[n]) + $signed(o[n]));
      assign xs[VEC_N-1-n] = tc_to_sm_sat($signed(e[n]) - $signed(o[n]));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         k     <= '0;
         vreg  <= '0;
         x_out <= '0;
      end else begin
         case (state)
            IDLE: if (in_valid) begin
               vreg  <= vin;
               k     <= '0;
               state <= MAC;
            end
            MAC: begin
               k <= k + 3'd1;
               if (k == 3'd7) state <= BFLY;
            end
            BFLY: begin
               x_out <= xs;
               state <= OUT;
            end
            OUT: if (out_ready) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
